// File: rtl/pulsar_spi_pkg.sv
// Shared word layout, command/state encodings and error-flag indices for the
// SPI register-write path.
package pulsar_spi_pkg;

  localparam int unsigned WORD_W = 24;
  localparam int unsigned REG_W  = 16;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned CMD_W  = 2;
  localparam int unsigned ERR_W  = 3;

  localparam int unsigned ERR_BAD_CMD  = 0;
  localparam int unsigned ERR_BAD_ADDR = 1;
  localparam int unsigned ERR_PROTOCOL = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP          = 2'b00,
    CMD_WRITE        = 2'b01,
    CMD_WRITE_COMMIT = 2'b10,
    CMD_RSVD         = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  typedef struct packed {
    cmd_e              cmd;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } word_t;

endpackage

// File: rtl/spi_reg_bank.sv
// Decodes received SPI words into a shadow register set and atomically
// commits it to the active registers when a clean transaction ends.
module spi_reg_bank
  import pulsar_spi_pkg::*;
#(
  parameter int unsigned NREGS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_W-1:0]      word,
  input  logic                   word_valid,
  input  logic                   xfer_start,
  input  logic                   xfer_end,
  input  logic                   err_clear,
  output logic [NREGS*REG_W-1:0] regs,
  output logic                   commit,
  output logic [ERR_W-1:0]       err
);

  localparam int unsigned AW1 = ADDR_W + 1;

  state_e           state_q, state_d;
  logic [REG_W-1:0] shadow_q [NREGS];
  logic [REG_W-1:0] shadow_d [NREGS];
  logic [REG_W-1:0] regs_q   [NREGS];
  logic [REG_W-1:0] regs_d   [NREGS];
  logic             dirty_q, dirty_d;
  logic             force_q, force_d;
  logic             commit_d;
  logic [ERR_W-1:0] err_set;

  word_t w;
  logic  is_write, bad_cmd, bad_addr;

  assign w        = word_t'(word);
  assign is_write = (w.cmd == CMD_WRITE) || (w.cmd == CMD_WRITE_COMMIT);
  assign bad_cmd  = (w.cmd == CMD_RSVD);
  assign bad_addr = is_write && (AW1'(w.addr) >= AW1'(NREGS));

  // Ordering within a cycle: close old transaction on start, then the word, then a lone end
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    regs_d   = regs_q;
    dirty_d  = dirty_q;
    force_d  = force_q;
    commit_d = 1'b0;
    err_set  = '0;

    if (xfer_start) begin
      if (xfer_end && (state_q == ST_ACTIVE) && (dirty_q || force_q)) begin
        regs_d   = shadow_q;
        commit_d = 1'b1;
      end
      if (!xfer_end && (state_q != ST_IDLE)) begin
        err_set[ERR_PROTOCOL] = 1'b1;
      end
      shadow_d = regs_d;
      dirty_d  = 1'b0;
      force_d  = 1'b0;
      state_d  = ST_ACTIVE;
    end

    if (word_valid) begin
      if (state_d == ST_IDLE) begin
        err_set[ERR_PROTOCOL] = 1'b1;
      end else if (state_d == ST_ACTIVE) begin
        if (bad_cmd || bad_addr) begin
          state_d               = ST_DISCARD;
          err_set[ERR_BAD_CMD]  = bad_cmd;
          err_set[ERR_BAD_ADDR] = bad_addr;
        end else if (is_write) begin
          for (int unsigned i = 0; i < NREGS; i++) begin
            if (w.addr == ADDR_W'(i)) shadow_d[i] = w.data;
          end
          dirty_d = 1'b1;
          if (w.cmd == CMD_WRITE_COMMIT) force_d = 1'b1;
        end
      end
    end

    if (xfer_end && !xfer_start) begin
      if ((state_d == ST_ACTIVE) && (dirty_d || force_d)) begin
        regs_d   = shadow_d;
        commit_d = 1'b1;
      end
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dirty_q <= 1'b0;
      force_q <= 1'b0;
      commit  <= 1'b0;
      err     <= '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        shadow_q[i] <= '0;
        regs_q[i]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      dirty_q  <= dirty_d;
      force_q  <= force_d;
      commit   <= commit_d;
      err      <= (err & ~{ERR_W{err_clear}}) | err_set;
      shadow_q <= shadow_d;
      regs_q   <= regs_d;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs[g*REG_W +: REG_W] = regs_q[g];
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: a transaction-level model tracks expected
// register/commit/error state and a negedge process compares every cycle.
module tb_spi_reg_bank;
  import pulsar_spi_pkg::*;

  localparam int unsigned N = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [23:0]     word;
  logic            word_valid, xfer_start, xfer_end, err_clear;
  logic [N*16-1:0] regs;
  logic            commit;
  logic [2:0]      err;

  spi_reg_bank #(.NREGS(N)) dut (
    .clk(clk), .reset(reset), .word(word), .word_valid(word_valid),
    .xfer_start(xfer_start), .xfer_end(xfer_end), .err_clear(err_clear),
    .regs(regs), .commit(commit), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int commit_cnt = 0;
  bit live = 0;

  // Model: open transaction, poisoned by an error, has something to commit
  logic [15:0] m_regs [N];
  logic [15:0] m_shadow [N];
  bit          m_open, m_poison, m_pending, m_commit;
  logic [2:0]  m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] r(input int i);
    return regs[16*i +: 16];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_regs[i]   = '0;
      m_shadow[i] = '0;
    end
    m_open = 0; m_poison = 0; m_pending = 0; m_commit = 0; m_err = '0;
  endtask

  task automatic model_apply(input bit s, input bit e, input bit v, input logic [23:0] w, input bit c);
    logic [2:0] set;
    int cmd, addr;
    set = '0;
    m_commit = 0;
    cmd  = int'(w[23:22]);
    addr = int'(w[21:16]);
    if (s) begin
      if (e && m_open && !m_poison && m_pending) begin
        m_regs = m_shadow;
        m_commit = 1;
      end
      if (!e && m_open) set[2] = 1'b1;
      m_shadow = m_regs;
      m_open = 1; m_poison = 0; m_pending = 0;
    end
    if (v) begin
      if (!m_open) set[2] = 1'b1;
      else if (!m_poison) begin
        if (cmd == 3) begin
          set[0] = 1'b1; m_poison = 1;
        end else if (cmd != 0 && addr >= int'(N)) begin
          set[1] = 1'b1; m_poison = 1;
        end else if (cmd != 0) begin
          m_shadow[addr] = w[15:0];
          m_pending = 1;
        end
      end
    end
    if (e && !s) begin
      if (m_open && !m_poison && m_pending) begin
        m_regs = m_shadow;
        m_commit = 1;
      end
      m_open = 0;
    end
    m_err = (c ? 3'b000 : m_err) | set;
  endtask

  task automatic step(input bit s, input bit e, input bit v, input logic [23:0] w, input bit c);
    xfer_start = s; xfer_end = e; word_valid = v; word = w; err_clear = c;
    @(posedge clk);
    model_apply(s, e, v, w, c);
    #1;
    xfer_start = 0; xfer_end = 0; word_valid = 0; word = '0; err_clear = 0;
  endtask

  task automatic idle();                  step(0, 0, 0, 24'h0, 0); endtask
  task automatic start();                 step(1, 0, 0, 24'h0, 0); endtask
  task automatic stop();                  step(0, 1, 0, 24'h0, 0); endtask
  task automatic wr(input logic [23:0] w); step(0, 0, 1, w, 0);    endtask
  task automatic clr();                   step(0, 0, 0, 24'h0, 1); endtask

  // Per-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (live && !reset) begin
      for (int i = 0; i < N; i++)
        check($sformatf("regs[%0d]", i), 64'(regs[16*i +: 16]), 64'(m_regs[i]));
      check("commit", 64'(commit), 64'(m_commit));
      check("err", 64'(err), 64'(m_err));
      if (commit) commit_cnt++;
    end
  end

  initial begin
    reset = 1'b1;
    word = '0; word_valid = 0; xfer_start = 0; xfer_end = 0; err_clear = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    live = 1;
    check("reset err", 64'(err), 64'(3'b000));
    check("reset regs", 64'(regs[63:0]), 64'h0);

    // Clean commit path
    commit_cnt = 0;
    start(); wr(24'h41_1234); wr(24'h43_ABCD); stop();
    check("commit regs1", 64'(r(1)), 64'h1234);
    check("commit regs3", 64'(r(3)), 64'hABCD);
    check("commit pulse", 64'(commit), 64'h1);
    idle();
    check("commit count", 64'(commit_cnt), 64'd1);
    check("commit err", 64'(err), 64'(3'b000));

    // Bad address discards the transaction
    commit_cnt = 0;
    start(); wr(24'h41_5555); wr(24'h50_0001); wr(24'h42_7777); stop(); idle();
    check("badaddr count", 64'(commit_cnt), 64'd0);
    check("badaddr regs1", 64'(r(1)), 64'h1234);
    check("badaddr err", 64'(err), 64'(3'b010));
    clr();
    check("badaddr cleared", 64'(err), 64'(3'b000));

    // Reserved command
    commit_cnt = 0;
    start(); wr(24'hC1_0000); wr(24'h43_9999); stop(); idle();
    check("rsvd count", 64'(commit_cnt), 64'd0);
    check("rsvd regs3", 64'(r(3)), 64'hABCD);
    check("rsvd err", 64'(err), 64'(3'b001));
    clr();

    // Missing xfer_end: reload drops the pending write
    commit_cnt = 0;
    start(); wr(24'h42_1111); start(); stop(); idle();
    check("noend err", 64'(err), 64'(3'b100));
    check("noend count", 64'(commit_cnt), 64'd0);
    check("noend regs2", 64'(r(2)), 64'h0);
    clr();

    // Forced commit and NOP-only transaction
    commit_cnt = 0;
    start(); wr(24'h85_00FF); stop(); idle();
    check("force regs5", 64'(r(5)), 64'h00FF);
    check("force count", 64'(commit_cnt), 64'd1);
    commit_cnt = 0;
    start(); wr(24'h00_0000); stop(); idle();
    check("nop count", 64'(commit_cnt), 64'd0);

    // Word and xfer_end together
    commit_cnt = 0;
    start(); wr(24'h41_0001); step(0, 1, 1, 24'h47_BEEF, 0); idle();
    check("wend regs1", 64'(r(1)), 64'h0001);
    check("wend regs7", 64'(r(7)), 64'hBEEF);
    check("wend count", 64'(commit_cnt), 64'd1);

    // Word and xfer_start together: word lands after reload
    commit_cnt = 0;
    start(); wr(24'h4A_1111); step(1, 0, 1, 24'h4A_2222, 0); stop(); idle();
    check("wstart regs10", 64'(r(10)), 64'h2222);
    check("wstart err", 64'(err), 64'(3'b100));
    check("wstart count", 64'(commit_cnt), 64'd1);
    clr();

    // xfer_start and xfer_end together: old transaction commits, no protocol
    commit_cnt = 0;
    start(); wr(24'h4B_3333); step(1, 1, 0, 24'h0, 0); wr(24'h4C_4444); stop(); idle();
    check("se regs11", 64'(r(11)), 64'h3333);
    check("se regs12", 64'(r(12)), 64'h4444);
    check("se err", 64'(err), 64'(3'b000));
    check("se count", 64'(commit_cnt), 64'd2);

    // Illegal word alongside xfer_end suppresses the commit
    commit_cnt = 0;
    start(); wr(24'h41_7777); step(0, 1, 1, 24'hC0_0000, 0); idle();
    check("illend regs1", 64'(r(1)), 64'h0001);
    check("illend count", 64'(commit_cnt), 64'd0);
    check("illend err", 64'(err), 64'(3'b001));
    clr();

    // word_valid in IDLE with a simultaneous clear: set wins
    step(0, 0, 1, 24'h41_9999, 1);
    check("idle word err", 64'(err), 64'(3'b100));
    check("idle word regs1", 64'(r(1)), 64'h0001);
    clr();
    commit_cnt = 0;
    stop(); idle();
    check("idle end err", 64'(err), 64'(3'b000));
    check("idle end count", 64'(commit_cnt), 64'd0);

    // Reset mid-transaction
    start(); wr(24'h41_AAAA);
    reset = 1'b1;
    #2;
    check("rst regs lo", 64'(regs[63:0]), 64'h0);
    check("rst regs5", 64'(r(5)), 64'h0);
    check("rst commit", 64'(commit), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    commit_cnt = 0;
    stop(); idle(); idle();
    check("post rst count", 64'(commit_cnt), 64'd0);
    check("post rst regs1", 64'(r(1)), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Register-write decoder and double-buffered register bank fed directly by the SPI slave receiver. It consumes complete 24-bit words and the transfer start/end strobes, then decodes each word as a command/address/data write into a shadow register set. When chip-select deasserts cleanly, it commits the shadow set atomically to the active registers that drive the pulse-generation logic. Transactions containing an error are never committed.

## Interface
- `NREGS`, default 16: number of 16-bit registers; legal range 1..64.
- `clk` input, 1 bit: system clock; same domain as the SPI receiver.
- `reset` input, 1 bit: asynchronous, active-high.
- `word` input, 24 bits: received word; sampled only when `word_valid` is high.
- `word_valid` input, 1 bit: one-cycle strobe, one per complete 24-bit word (receiver's `data_ready`).
- `xfer_start` input, 1 bit: one-cycle strobe at chip-select assertion (`new_transfer`).
- `xfer_end` input, 1 bit: one-cycle strobe at chip-select deassertion (`transfer_done`).
- `err_clear` input, 1 bit: clears all sticky error flags.
- `regs` output, NREGS*16 bits: active registers, flat; register i occupies bits [16*i+15:16*i].
- `commit` output, 1 bit: one-cycle strobe, high in the same cycle `regs` first shows newly committed values.
- `err` output, 3 bits: sticky flags {protocol, bad_addr, bad_cmd}.

## Operation
- Word format:
  - [23:22]: cmd.
  - [21:16]: addr.
  - [15:0]: data.
- Commands:
  - 2'b00 NOP: no effect.
  - 2'b01 WRITE: write data to shadow[addr] and set dirty.
  - 2'b10 WRITE_COMMIT: same as WRITE, and also sets force_commit.
  - 2'b11 reserved: bad_cmd.
- Address check: addr >= NREGS sets bad_addr. The word is not written and the FSM enters DISCARD.
- FSM states:
  - IDLE to ACTIVE on xfer_start.
  - ACTIVE to DISCARD on bad_cmd or bad_addr.
  - ACTIVE to IDLE on xfer_end, committing if dirty.
  - DISCARD to IDLE on xfer_end, no commit.
  - Any state to ACTIVE on xfer_start.
- On xfer_start:
  - Reload shadow from regs, which discards uncommitted writes from an aborted transaction.
  - Clear dirty.
  - If the state was ACTIVE or DISCARD, set protocol (missing xfer_end).
- In DISCARD, all words are ignored. A WRITE_COMMIT received in ACTIVE forces a commit at xfer_end even if no other write has occurred; in DISCARD it is ignored.
- word_valid in IDLE: the word is ignored and protocol is set.
- xfer_end in IDLE: ignored, and no flag is set.
- Error flags:
  - Set on the cycle after the detecting event.
  - Cleared by err_clear.
  - If set and clear occur in the same cycle, set wins.
- Reset values:
  - regs: all zero.
  - Shadow: all zero.
  - State: IDLE.
  - commit: 0.
  - err: 3'b000.
  - dirty and force_commit: 0.

## Timing
- Shadow write: visible in the shadow one cycle after word_valid.
- Commit: `regs` and `commit` both update on the clock edge following xfer_end. Latency from xfer_end to new `regs` is 1 cycle, and all registers update on that same edge.
- word_valid and xfer_end in the same cycle: the word is decoded first. A legal write is included in the commit; an illegal word suppresses the commit.
- word_valid and xfer_start in the same cycle: the shadow reloads, then the word is applied as the first word of the new transaction (write data overrides the reloaded value).
- xfer_start and xfer_end in the same cycle: xfer_end is processed for the old transaction, then xfer_start. Protocol is not set.
- Reset asserted mid-transaction: the block returns to its reset state immediately, and no commit is issued.
- Throughput: one word per cycle sustained; the block never stalls the input.

## Structure
- The package `pulsar_spi_pkg` holds:
  - cmd enum: CMD_NOP, CMD_WRITE, CMD_WRITE_COMMIT, CMD_RSVD.
  - Field bit positions and widths: WORD_W = 24, REG_W = 16, ADDR_W = 6.
  - FSM state enum: ST_IDLE, ST_ACTIVE, ST_DISCARD.
  - err bit indices.
- There is one module and no sub-module; the register arrays are inline. Expected size is roughly 150–200 lines.

## Test plan
- Commit path:
  - Stimulus, NREGS = 16: xfer_start, then words 0x41_1234 (WRITE addr1) and 0x43_ABCD (WRITE addr3), then xfer_end.
  - Response: one cycle after xfer_end, regs[1] = 0x1234, regs[3] = 0xABCD, commit pulses once, err = 0.
- Bad address:
  - Stimulus: xfer_start, 0x41_5555, 0x50_0001 (addr 16), 0x42_7777, xfer_end.
  - Response: no commit, regs unchanged, err = 3'b010.
  - Then err_clear, after which err = 0.
- Reserved command: a word with cmd 2'b11 -> err = 3'b001, the transaction is discarded, and no commit occurs.
- Missing xfer_end:
  - Stimulus: xfer_start, 0x42_1111, a second xfer_start, xfer_end.
  - Response: err = 3'b100; no commit, because the 0x42_1111 write was discarded by the reload.
- Forced commit:
  - Stimulus: xfer_start, a lone WRITE_COMMIT 0x85_00FF, xfer_end.
  - Response: regs[5] = 0x00FF and commit pulses.
  - Also: a NOP-only transaction produces no commit.
- Edge cases:
  - word_valid and xfer_end in the same cycle: the write is included in the commit.
  - Reset asserted mid-transaction: regs = 0 and no commit pulse.
